fir_sample_source: RTL and testbench

Programmable test-pattern generator that produces the 8-bit sample stream feeding the `tt_um_fir` filter input. It is the transmit end of the FIR sample interface: it emits impulse, step, ramp or pseudo-random bursts at a programmable rate, so the filter can be exercised on-chip without external stimulus. Configuration arrives through the bidirectional IO byte; the burst is launched by a start pulse.

---
 rtl/fir_sample_source.sv | 172 +++++++++++++++++
 tb/tb_fir_sample_source.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_source.sv
// Programmable impulse/step/ramp/PRBS burst generator driving the FIR sample input.
// Configuration is written through a 2-bit addressed byte port; a start pulse launches a burst.
module fir_sample_source #(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] cfg_data,
    input  logic [1:0] cfg_addr,
    input  logic       cfg_wr,
    input  logic       start,
    output logic [7:0] sample_out,
    output logic       sample_strobe,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DW = 8;
    localparam int unsigned MW = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mode_q, mode_d;
    logic [DW-1:0]   div_q, div_d;
    logic [DW-1:0]   len_q, len_d;
    logic [DW-1:0]   amp_q, amp_d;
    logic [MW-1:0]   run_mode_q, run_mode_d;
    logic [DW-1:0]   run_div_q, run_div_d;
    logic [DW-1:0]   run_len_q, run_len_d;
    logic [DW-1:0]   run_amp_q, run_amp_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   lfsr_q, lfsr_d;
    logic [DW-1:0]   sample_d;
    logic            strobe_d, busy_d, done_d;
    logic [DW-1:0]   lfsr_next_c;
    logic [DW-1:0]   sample_val_c;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
    assign lfsr_next_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        sample_val_c = lfsr_q;
        case (run_mode_q)
            2'd0:    sample_val_c = (idx_q == '0) ? run_amp_q : '0;
            2'd1:    sample_val_c = run_amp_q;
            2'd2:    sample_val_c = DW'(run_amp_q + idx_q);
            default: sample_val_c = lfsr_q;
        endcase
    end

    // Next-state, configuration writes and registered output values
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        div_d      = div_q;
        len_d      = len_q;
        amp_d      = amp_q;
        run_mode_d = run_mode_q;
        run_div_d  = run_div_q;
        run_len_d  = run_len_q;
        run_amp_d  = run_amp_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        lfsr_d     = lfsr_q;
        sample_d   = sample_out;
        strobe_d   = 1'b0;
        busy_d     = busy;
        done_d     = done;

        if (cfg_wr && !busy) begin
            case (cfg_addr)
                2'd0:    mode_d = cfg_data[MW-1:0];
                2'd1:    div_d  = cfg_data;
                2'd2:    len_d  = cfg_data;
                default: amp_d  = cfg_data;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Burst snapshots the pre-write register values
                    state_d    = S_RUN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    lfsr_d     = LFSR_SEED;
                    run_mode_d = mode_q;
                    run_div_d  = div_q;
                    run_len_d  = len_q;
                    run_amp_d  = amp_q;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    strobe_d = 1'b1;
                    sample_d = sample_val_c;
                    cnt_d    = run_div_q;
                    idx_d    = DW'(idx_q + 8'd1);
                    if (run_mode_q == 2'd3) begin
                        lfsr_d = lfsr_next_c;
                    end
                    // LEN of zero wraps to 255 here, giving 256 samples
                    if (idx_q == DW'(run_len_q - 8'd1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = DW'(cnt_q - 8'd1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; ena low freezes everything but the strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            div_q         <= '0;
            len_q         <= 8'd16;
            amp_q         <= 8'h40;
            run_mode_q    <= '0;
            run_div_q     <= '0;
            run_len_q     <= 8'd16;
            run_amp_q     <= 8'h40;
            cnt_q         <= '0;
            idx_q         <= '0;
            lfsr_q        <= LFSR_SEED;
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (ena) begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            div_q         <= div_d;
            len_q         <= len_d;
            amp_q         <= amp_d;
            run_mode_q    <= run_mode_d;
            run_div_q     <= run_div_d;
            run_len_q     <= run_len_d;
            run_amp_q     <= run_amp_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            lfsr_q        <= lfsr_d;
            sample_out    <= sample_d;
            sample_strobe <= strobe_d;
            busy          <= busy_d;
            done          <= done_d;
        end else begin
            sample_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_sample_source.sv
// Self-checking bench for fir_sample_source: scoreboard of expected samples,
// strobe timing, busy/done behaviour, ena freeze, reset abort and ignored starts.
module tb_fir_sample_source;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] cfg_data;
    logic [1:0] cfg_addr;
    logic       cfg_wr;
    logic       start;
    logic [7:0] sample_out;
    logic       sample_strobe;
    logic       busy;
    logic       done;

    int         errors;
    int         checks;
    int         cyc;
    int         start_cyc;
    int         strobe_cnt;
    int         strobe_cyc[$];
    logic [7:0] sb[$];
    logic [7:0] last_exp;

    fir_sample_source #(.LFSR_SEED(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cfg_data     (cfg_data),
        .cfg_addr     (cfg_addr),
        .cfg_wr       (cfg_wr),
        .start        (start),
        .sample_out   (sample_out),
        .sample_strobe(sample_strobe),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard consumer
    always @(negedge clk) begin
        if (sample_strobe === 1'b1) begin
            strobe_cnt++;
            strobe_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got sample %h at cycle %0d, none expected", sample_out, cyc);
            end else begin
                logic [7:0] exp_v;
                exp_v = sb.pop_front();
                if (sample_out !== exp_v) begin
                    errors++;
                    $display("FAIL sample: got %h expected %h at cycle %0d", sample_out, exp_v, cyc);
                end
            end
        end
    end

    // Reference model of one burst
    task automatic push_expected(input logic [1:0] mode, input logic [7:0] amp, input logic [7:0] len);
        int         n;
        logic [7:0] s;
        logic [7:0] v;
        n = (len == 8'd0) ? 256 : int'(len);
        s = 8'hA5;
        for (int i = 0; i < n; i++) begin
            case (mode)
                2'd0:    v = (i == 0) ? amp : 8'h00;
                2'd1:    v = amp;
                2'd2:    v = 8'(amp + 8'(i));
                default: begin
                    v = s;
                    s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
                end
            endcase
            sb.push_back(v);
            last_exp = v;
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_addr = a;
        cfg_data = d;
        cfg_wr   = 1'b1;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    task automatic setup(input logic [1:0] mode, input logic [7:0] amp, input logic [7:0] len,
                         input logic [7:0] div);
        cfg_write(2'd0, {6'd0, mode});
        cfg_write(2'd3, amp);
        cfg_write(2'd2, len);
        cfg_write(2'd1, div);
    endtask

    task automatic pulse_start(input string name);
        strobe_cnt = 0;
        strobe_cyc.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_launch: busy=%b done=%b, expected busy=1 done=0", name, busy, done);
        end
    endtask

    task automatic start_burst(input logic [1:0] mode, input logic [7:0] amp, input logic [7:0] len,
                               input string name);
        push_expected(mode, amp, len);
        pulse_start(name);
    endtask

    task automatic wait_done(input int n, input int div, input int gap, input string name);
        int exp_fall;
        int span;
        exp_fall = start_cyc + 2 + (n - 1) * (div + 1) + gap;
        for (int g = 0; g < 4000 && busy === 1'b1; g++) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || cyc != exp_fall) begin
            errors++;
            $display("FAIL %s_end: busy=%b done=%b at cycle %0d, expected busy=0 done=1 at cycle %0d",
                     name, busy, done, cyc, exp_fall);
        end
        checks++;
        if (strobe_cnt != n) begin
            errors++;
            $display("FAIL %s_count: got %0d strobes expected %0d", name, strobe_cnt, n);
        end
        if (strobe_cyc.size() > 0) begin
            checks++;
            if (strobe_cyc[0] != start_cyc + 1) begin
                errors++;
                $display("FAIL %s_first: first strobe cycle %0d expected %0d", name, strobe_cyc[0], start_cyc + 1);
            end
            span = strobe_cyc[strobe_cyc.size() - 1] - strobe_cyc[0];
            checks++;
            if (span != (n - 1) * (div + 1) + gap) begin
                errors++;
                $display("FAIL %s_span: strobe span %0d expected %0d", name, span, (n - 1) * (div + 1) + gap);
            end
            if (gap == 0) begin
                for (int i = 1; i < strobe_cyc.size(); i++) begin
                    checks++;
                    if (strobe_cyc[i] - strobe_cyc[i - 1] != div + 1) begin
                        errors++;
                        $display("FAIL %s_spacing: gap %0d expected %0d at strobe %0d",
                                 name, strobe_cyc[i] - strobe_cyc[i - 1], div + 1, i);
                    end
                end
            end
        end
        checks++;
        if (sb.size() != 0 || sample_out !== last_exp) begin
            errors++;
            $display("FAIL %s_hold: %0d samples pending, sample_out=%h expected %h",
                     name, sb.size(), sample_out, last_exp);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sample_out !== 8'h00 || sample_strobe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out=%h strobe=%b busy=%b done=%b, expected all 0",
                     sample_out, sample_strobe, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // Defaults: impulse, DIV 0, LEN 16, AMP 40
        start_burst(2'd0, 8'h40, 8'd16, "reset_defaults");
        wait_done(16, 0, 0, "reset_defaults");
    endtask

    task automatic test_impulse();
        setup(2'd0, 8'h7F, 8'd4, 8'd0);
        start_burst(2'd0, 8'h7F, 8'd4, "impulse");
        wait_done(4, 0, 0, "impulse");
    endtask

    task automatic test_ramp();
        setup(2'd2, 8'hFE, 8'd4, 8'd2);
        start_burst(2'd2, 8'hFE, 8'd4, "ramp");
        wait_done(4, 2, 0, "ramp");
    endtask

    task automatic test_prbs();
        setup(2'd3, 8'h00, 8'd3, 8'd0);
        start_burst(2'd3, 8'h00, 8'd3, "prbs");
        wait_done(3, 0, 0, "prbs");
        start_burst(2'd3, 8'h00, 8'd3, "prbs_again");
        wait_done(3, 0, 0, "prbs_again");
    endtask

    task automatic test_len_zero();
        setup(2'd1, 8'h33, 8'd0, 8'd0);
        start_burst(2'd1, 8'h33, 8'd0, "len0");
        repeat (50) @(negedge clk);
        cfg_write(2'd3, 8'h99);
        wait_done(256, 0, 0, "len0");
        // AMP must still hold the pre-burst value
        cfg_write(2'd2, 8'd1);
        start_burst(2'd1, 8'h33, 8'd1, "len0_amp_kept");
        wait_done(1, 0, 0, "len0_amp_kept");
    endtask

    task automatic test_ena_gap();
        setup(2'd2, 8'h10, 8'd6, 8'd1);
        start_burst(2'd2, 8'h10, 8'd6, "ena_gap");
        repeat (3) @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (sample_strobe !== 1'b0) begin
                errors++;
                $display("FAIL ena_gap_strobe: strobe=%b during ena low cycle %0d, expected 0", sample_strobe, i);
            end
        end
        ena = 1'b1;
        wait_done(6, 1, 5, "ena_gap");
    endtask

    task automatic test_reset_abort();
        int cnt_before;
        setup(2'd1, 8'h44, 8'd10, 8'd1);
        start_burst(2'd1, 8'h44, 8'd10, "abort");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (sample_out !== 8'h00 || sample_strobe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: out=%h strobe=%b busy=%b done=%b, expected all 0",
                     sample_out, sample_strobe, busy, done);
        end
        rst_n = 1'b1;
        sb.delete();
        cnt_before = strobe_cnt;
        repeat (12) @(negedge clk);
        checks++;
        if (strobe_cnt != cnt_before || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: %0d strobes after reset, busy=%b, expected 0 and 0",
                     strobe_cnt - cnt_before, busy);
        end
    endtask

    task automatic test_start_while_busy();
        setup(2'd1, 8'h11, 8'd5, 8'd1);
        start_burst(2'd1, 8'h11, 8'd5, "busy_start");
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 1, 0, "busy_start");
    endtask

    task automatic test_same_cycle();
        setup(2'd1, 8'h20, 8'd2, 8'd0);
        push_expected(2'd1, 8'h20, 8'd2);
        cfg_addr = 2'd3;
        cfg_data = 8'h55;
        cfg_wr   = 1'b1;
        pulse_start("same_cycle");
        cfg_wr   = 1'b0;
        wait_done(2, 0, 0, "same_cycle");
        start_burst(2'd1, 8'h55, 8'd2, "same_cycle_next");
        wait_done(2, 0, 0, "same_cycle_next");
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        cfg_data = 8'h00;
        cfg_addr = 2'd0;
        cfg_wr   = 1'b0;
        start    = 1'b0;
        last_exp = 8'h00;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_ramp();
        test_prbs();
        test_len_zero();
        test_ena_gap();
        test_start_while_busy();
        test_same_cycle();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
